aes_sub_bytes_seq: RTL and testbench

//  Iterative forward AES SubBytes engine for the encryption datapath.
//  - Accepts one 128-bit state over a valid/ready handshake.
//  - Substitutes LANES bytes per clock through the FIPS-197 forward S-box (S(00)=63, S(53)=ED).
//  - Returns the result over a second valid/ready handshake.
//  - Sits between AddRoundKey and ShiftRows in the round controller.

---
 rtl/aes_sub_bytes_seq.sv | 137 +++++++++++++
 tb/tb_aes_sub_bytes_seq.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/aes_sub_bytes_seq.sv
// Iterative AES SubBytes engine: LANES bytes per clock through the S-box, valid/ready in and out.
// Optional inverse S-box selection is compiled in when AES_SUB_BYTES_INV_EN is defined.
module aes_sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic         i_Valid,
  output logic         o_Ready,
  input  logic [127:0] i_Din,
`ifdef AES_SUB_BYTES_INV_EN
  input  logic         i_Inv,
`endif
  output logic         o_Valid,
  input  logic         i_Ready,
  output logic [127:0] o_Dout,
  output logic         o_Busy
);

  localparam int ROUNDS_N = 16 / LANES;
  localparam int CNT_W    = (ROUNDS_N > 1) ? $clog2(ROUNDS_N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROUNDS_N - 1);

  // Entry 0 is the leftmost byte (index 255), so the entry for byte b is TABLE[~b].
  localparam logic [255:0][7:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

`ifdef AES_SUB_BYTES_INV_EN
  localparam logic [255:0][7:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic inv);
    return inv ? SBOX_INV[~b] : SBOX_FWD[~b];
  endfunction
`else
  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX_FWD[~b];
  endfunction
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_SUB, ST_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Byte k of the block (i_Din[127-8k -: 8]) lives at data_q[15-k].
  logic [15:0][7:0] data_q, data_d;
`ifdef AES_SUB_BYTES_INV_EN
  logic             inv_q, inv_d;
`endif

  assign o_Ready = (state_q == ST_IDLE) && !i_Rst;
  assign o_Valid = (state_q == ST_DONE);
  assign o_Busy  = (state_q == ST_SUB) || (state_q == ST_DONE);
  assign o_Dout  = data_q;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
`ifdef AES_SUB_BYTES_INV_EN
    inv_d   = inv_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_Valid && o_Ready) begin
          data_d  = i_Din;
          cnt_d   = '0;
          state_d = ST_SUB;
`ifdef AES_SUB_BYTES_INV_EN
          inv_d   = i_Inv;
`endif
        end
      end
      ST_SUB: begin
        // One S-box lookup per lane, covering bytes cnt*LANES .. cnt*LANES+LANES-1.
        for (int l = 0; l < LANES; l++) begin
`ifdef AES_SUB_BYTES_INV_EN
          data_d[4'(15 - int'(cnt_q) * LANES - l)] =
            sub_byte(data_q[4'(15 - int'(cnt_q) * LANES - l)], inv_q);
`else
          data_d[4'(15 - int'(cnt_q) * LANES - l)] =
            sub_byte(data_q[4'(15 - int'(cnt_q) * LANES - l)]);
`endif
        end
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (i_Ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      // NOTE: the data register is reset because o_Dout must read zero after reset.
      data_q  <= '0;
`ifdef AES_SUB_BYTES_INV_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
`ifdef AES_SUB_BYTES_INV_EN
      inv_q   <= inv_d;
`endif
    end
  end

endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// Directed bench for aes_sub_bytes_seq: one instance per LANES value (4,1,2,8,16) on a shared clock.
// Instance 0 (LANES=4) carries reset, data, backpressure and abort scenarios; the rest check latency.
module tb_aes_sub_bytes_seq;

  localparam int NDUT = 5;
  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

  logic         clk;
  logic         rst;
  logic [127:0] din;
  logic         ready_in;
  logic         inv;
  logic         valid_in [NDUT];
  logic         rdy_out  [NDUT];
  logic         vout     [NDUT];
  logic         busy     [NDUT];
  logic [127:0] dout     [NDUT];
  int           lanes_of [NDUT];

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int LN = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : (g == 3) ? 8 : 16;
    assign lanes_of[g] = LN;
    aes_sub_bytes_seq #(.LANES(LN)) u_dut (
      .i_Clk   (clk),
      .i_Rst   (rst),
      .i_Valid (valid_in[g]),
      .o_Ready (rdy_out[g]),
      .i_Din   (din),
`ifdef AES_SUB_BYTES_INV_EN
      .i_Inv   (inv),
`endif
      .o_Valid (vout[g]),
      .i_Ready (ready_in),
      .o_Dout  (dout[g]),
      .o_Busy  (busy[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Sends one block to instance d and measures edges from accept to o_Valid.
  task automatic run_block(input int d, input logic [127:0] blk, input logic [127:0] exp,
                           input int exp_lat, input string tag);
    int lat;
    check({tag, " ready_before"}, 128'(rdy_out[d]), 128'd1);
    din = blk;
    valid_in[d] = 1'b1;
    @(posedge clk); #1;
    valid_in[d] = 1'b0;
    din = ~blk;
    check({tag, " busy_after_accept"}, 128'(busy[d]), 128'd1);
    lat = 0;
    while (!vout[d] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 128'(lat), 128'(exp_lat));
    check({tag, " dout"}, dout[d], exp);
    if (ready_in) begin
      @(posedge clk); #1;
      check({tag, " valid_one_cycle"}, 128'(vout[d]), 128'd0);
      check({tag, " ready_after"}, 128'(rdy_out[d]), 128'd1);
    end
  endtask

  initial begin
    int lat;
    logic seen;
    rst      = 1'b1;
    din      = '0;
    ready_in = 1'b1;
    inv      = 1'b0;
    for (int i = 0; i < NDUT; i++) valid_in[i] = 1'b0;

    // Reset held for three clocks.
    repeat (3) @(posedge clk);
    #1;
    check("rst valid", 128'(vout[0]), 128'd0);
    check("rst ready", 128'(rdy_out[0]), 128'd0);
    check("rst busy", 128'(busy[0]), 128'd0);
    check("rst dout", dout[0], 128'd0);
    rst = 1'b0;
    #1;
    check("rst ready_release", 128'(rdy_out[0]), 128'd1);

    // FIPS vector and edge data on LANES=4.
    run_block(0, FIPS_IN, FIPS_OUT, 4, "fips");
    run_block(0, 128'd0, {16{8'h63}}, 4, "all00");
    run_block(0, {16{8'hff}}, {16{8'h16}}, 4, "allff");
    run_block(0, 128'h000102030405060708090a0b0c0d0e0f,
              128'h637c777bf26b6fc53001672bfed7ab76, 4, "incr");

    // Backpressure: hold DONE for ten clocks while i_Valid toggles.
    ready_in = 1'b0;
    run_block(0, FIPS_IN, FIPS_OUT, 4, "bp");
    for (int i = 0; i < 10; i++) begin
      valid_in[0] = (i % 2 == 0);
      din = 128'(i) * 128'h0101_0101;
      @(posedge clk); #1;
      check($sformatf("bp hold_valid %0d", i), 128'(vout[0]), 128'd1);
      check($sformatf("bp hold_dout %0d", i), dout[0], FIPS_OUT);
      check($sformatf("bp hold_ready %0d", i), 128'(rdy_out[0]), 128'd0);
    end
    valid_in[0] = 1'b0;
    ready_in = 1'b1;
    @(posedge clk); #1;
    check("bp release_valid", 128'(vout[0]), 128'd0);
    check("bp release_ready", 128'(rdy_out[0]), 128'd1);
    check("bp release_busy", 128'(busy[0]), 128'd0);
    repeat (3) @(posedge clk);
    #1;
    check("bp nothing_queued", 128'(busy[0]), 128'd0);

    // Abort at SUB beat 2.
    din = FIPS_IN;
    valid_in[0] = 1'b1;
    @(posedge clk); #1;
    valid_in[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort ready_in_rst", 128'(rdy_out[0]), 128'd0);
    check("abort valid", 128'(vout[0]), 128'd0);
    check("abort busy", 128'(busy[0]), 128'd0);
    check("abort dout", dout[0], 128'd0);
    rst = 1'b0;
    #1;
    check("abort ready_release", 128'(rdy_out[0]), 128'd1);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      seen = seen | vout[0];
    end
    check("abort no_valid", 128'(seen), 128'd0);
    run_block(0, FIPS_IN, FIPS_OUT, 4, "rerun");

    // Latency sweep across LANES.
    for (int g = 1; g < NDUT; g++) begin
      run_block(g, FIPS_IN, FIPS_OUT, 16 / lanes_of[g], $sformatf("lanes%0d", lanes_of[g]));
    end

`ifdef AES_SUB_BYTES_INV_EN
    inv = 1'b1;
    run_block(0, FIPS_OUT, FIPS_IN, 4, "inv");
    for (int g = 1; g < NDUT; g++) begin
      run_block(g, FIPS_OUT, FIPS_IN, 16 / lanes_of[g], $sformatf("inv_lanes%0d", lanes_of[g]));
    end
    inv = 1'b0;
    run_block(0, FIPS_IN, FIPS_OUT, 4, "fwd_after_inv");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
